// File: rtl/writeback_stage_pkg.sv
// Shared encodings for the writeback stage: micro-op codes, flag indices,
// condition codes and the writeback FSM states.
package writeback_stage_pkg;

    localparam int UOP_W = 5;

    typedef enum logic [UOP_W-1:0] {
        UOP_ADD = 5'd0,
        UOP_SUB = 5'd1,
        UOP_AND = 5'd2,
        UOP_EOR = 5'd3,
        UOP_LSL = 5'd4,
        UOP_LSR = 5'd5,
        UOP_MOV = 5'd6,
        UOP_CMP = 5'd7,
        UOP_STR = 5'd8,
        UOP_LDR = 5'd9
    } uop_e;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

    typedef enum logic [3:0] {
        CC_EQ, CC_NE, CC_CS, CC_CC, CC_MI, CC_PL, CC_VS, CC_VC,
        CC_HI, CC_LS, CC_GE, CC_LT, CC_GT, CC_LE, CC_AL, CC_NV
    } cond_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEM,
        S_LDWB
    } state_e;

endpackage

// File: rtl/writeback_stage_cond_check.sv
// Combinational condition evaluator: flags [Z,C,N,V] + condition code -> pass.
module cond_check
    import writeback_stage_pkg::*;
(
    input  logic [3:0] flags,
    input  logic [3:0] cond,
    output logic       pass
);

    logic z, c, n, v;

    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign n = flags[FLAG_N];
    assign v = flags[FLAG_V];

    always_comb begin
        pass = 1'b0;
        case (cond_e'(cond))
            CC_EQ:   pass = z;
            CC_NE:   pass = !z;
            CC_CS:   pass = c;
            CC_CC:   pass = !c;
            CC_MI:   pass = n;
            CC_PL:   pass = !n;
            CC_VS:   pass = v;
            CC_VC:   pass = !v;
            CC_HI:   pass = c && !z;
            CC_LS:   pass = !c || z;
            CC_GE:   pass = (n == v);
            CC_LT:   pass = (n != v);
            CC_GT:   pass = !z && (n == v);
            CC_LE:   pass = z || (n != v);
            CC_AL:   pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Retires ALU micro-ops: owns the flags register, runs the LDR/STR memory
// handshake with a timeout, and issues the single register-file write.
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int REG_AW      = 4,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [UOP_W-1:0]  uop,
    input  logic [REG_AW-1:0] rd,
    input  logic              set_flags,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [3:0]        alu_flags,
    input  logic [DATA_W-1:0] store_data,
    input  logic [3:0]        cond,
    output logic              cond_pass,
    output logic [3:0]        flags,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              fault
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    state_e            state, state_n;
    logic [CNT_W-1:0]  cnt;
    logic [REG_AW-1:0] ld_rd;
    logic              accept;
    logic              is_mem_op;
    logic              tmo;

    assign in_ready  = (state == S_IDLE) && !reset;
    assign accept    = in_valid && in_ready;
    assign is_mem_op = (uop_e'(uop) == UOP_STR) || (uop_e'(uop) == UOP_LDR);
    // Last permitted wait cycle; an ack here still takes priority.
    assign tmo       = (cnt == CNT_W'(MEM_TIMEOUT - 1));

    cond_check u_cond (
        .flags (flags),
        .cond  (cond),
        .pass  (cond_pass)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (accept && is_mem_op) state_n = S_MEM;
            S_MEM: begin
                if (mem_ack)  state_n = mem_we ? S_IDLE : S_LDWB;
                else if (tmo) state_n = S_IDLE;
            end
            S_LDWB:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            fault     <= 1'b0;
            cnt       <= '0;
            ld_rd     <= '0;
        end else begin
            rf_we <= 1'b0;
            case (state)
                S_IDLE: if (accept) begin
                    case (uop_e'(uop))
                        UOP_ADD, UOP_SUB, UOP_LSL: begin
                            rf_we    <= 1'b1;
                            rf_waddr <= rd;
                            rf_wdata <= alu_out;
                            if (set_flags) flags <= alu_flags;
                        end
                        // Logical ops leave carry/overflow alone.
                        UOP_AND, UOP_EOR, UOP_LSR, UOP_MOV: begin
                            rf_we    <= 1'b1;
                            rf_waddr <= rd;
                            rf_wdata <= alu_out;
                            if (set_flags) begin
                                flags[FLAG_Z] <= alu_flags[FLAG_Z];
                                flags[FLAG_N] <= alu_flags[FLAG_N];
                            end
                        end
                        UOP_CMP: flags <= alu_flags;
                        UOP_STR, UOP_LDR: begin
                            mem_req   <= 1'b1;
                            mem_we    <= (uop_e'(uop) == UOP_STR);
                            mem_addr  <= alu_out;
                            mem_wdata <= store_data;
                            ld_rd     <= rd;
                            cnt       <= '0;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            rf_we    <= 1'b1;
                            rf_waddr <= ld_rd;
                            rf_wdata <= mem_rdata;
                        end
                    end else if (tmo) begin
                        mem_req <= 1'b0;
                        fault   <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: expected register writes and memory
// requests are queued at issue time and checked by independent monitors.
module tb_writeback_stage;
    import writeback_stage_pkg::*;

    localparam logic [3:0] FZ = 4'b0001, FC = 4'b0010, FN = 4'b0100, FV = 4'b1000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  uop = '0;
    logic [3:0]  rd = '0;
    logic        set_flags = 1'b0;
    logic [31:0] alu_out = '0;
    logic [3:0]  alu_flags = '0;
    logic [31:0] store_data = '0;
    logic [3:0]  cond = '0;
    logic        cond_pass;
    logic [3:0]  flags;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        fault;

    typedef struct { logic [3:0] a; logic [31:0] d; } rfx_t;
    typedef struct { logic we; logic [31:0] a; logic [31:0] d; } memx_t;
    rfx_t  rf_q[$];
    memx_t mem_q[$];

    int nvec = 0;
    int nerr = 0;

    writeback_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .uop(uop), .rd(rd), .set_flags(set_flags), .alu_out(alu_out),
        .alu_flags(alu_flags), .store_data(store_data), .cond(cond),
        .cond_pass(cond_pass), .flags(flags), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Register-file write monitor.
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            if (rf_q.size() == 0) begin
                chk("rf_we unexpected", 32'(rf_waddr), 32'hFFFF_FFFF);
            end else begin
                rfx_t e;
                e = rf_q.pop_front();
                chk("rf_waddr", 32'(rf_waddr), 32'(e.a));
                chk("rf_wdata", rf_wdata, e.d);
            end
        end
    end

    // Memory request monitor: check new requests and stability while held.
    logic        req_prev = 1'b0;
    logic        held_we;
    logic [31:0] held_a, held_d;
    always @(negedge clk) begin
        if (mem_req === 1'b1 && !req_prev) begin
            if (mem_q.size() == 0) begin
                chk("mem_req unexpected", mem_addr, 32'hFFFF_FFFF);
            end else begin
                memx_t e;
                e = mem_q.pop_front();
                chk("mem_we", 32'(mem_we), 32'(e.we));
                chk("mem_addr", mem_addr, e.a);
                if (e.we) chk("mem_wdata", mem_wdata, e.d);
            end
            held_we = mem_we; held_a = mem_addr; held_d = mem_wdata;
        end else if (mem_req === 1'b1) begin
            if (mem_we !== held_we || mem_addr !== held_a || (held_we && mem_wdata !== held_d))
                chk("mem held stable", mem_addr, held_a ^ 32'h1);
        end
        req_prev = (mem_req === 1'b1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] u, input logic [3:0] r, input logic sf,
                         input logic [31:0] ao, input logic [3:0] af, input logic [31:0] sd);
        in_valid = 1'b1; uop = u; rd = r; set_flags = sf;
        alu_out = ao; alu_flags = af; store_data = sd;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic chk_cond(input logic [3:0] c, input logic exp);
        cond = c;
        #1;
        chk($sformatf("cond_pass cc=%0d", c), 32'(cond_pass), 32'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset state
        tick(); tick();
        chk("in_ready in reset", 32'(in_ready), 32'd0);
        reset = 1'b0;
        #1;
        chk("flags after reset", 32'(flags), 32'd0);
        chk("fault after reset", 32'(fault), 32'd0);
        chk("mem_req after reset", 32'(mem_req), 32'd0);
        chk("in_ready idle", 32'(in_ready), 32'd1);

        // ADD with flags: C set
        rf_q.push_back('{4'd3, 32'd5});
        issue(UOP_ADD, 4'd3, 1'b1, 32'd5, FC, 32'd0);
        chk("flags ADD", 32'(flags), 32'(FC));
        chk_cond(4'd2, 1'b1);
        chk_cond(4'd3, 1'b0);

        // CMP always updates, never writes
        issue(UOP_CMP, 4'd4, 1'b0, 32'd0, FZ, 32'd0);
        chk("flags CMP", 32'(flags), 32'(FZ));
        chk_cond(4'd0, 1'b1);
        chk_cond(4'd1, 1'b0);

        // Back-to-back: ADD sets C,N then MOV keeps C,V and loads Z,N
        rf_q.push_back('{4'd1, 32'h11});
        issue(UOP_ADD, 4'd1, 1'b1, 32'h11, FC | FN, 32'd0);
        chk("flags pre-MOV", 32'(flags), 32'(FC | FN));
        rf_q.push_back('{4'd2, 32'h22});
        issue(UOP_MOV, 4'd2, 1'b1, 32'h22, FZ, 32'd0);
        chk("flags MOV", 32'(flags), 32'(FZ | FC));

        // Logical op without set_flags, and an unknown uop: flags untouched
        rf_q.push_back('{4'd5, 32'hF0F0});
        issue(UOP_AND, 4'd5, 1'b0, 32'hF0F0, 4'b1111, 32'd0);
        issue(5'd20, 4'd6, 1'b1, 32'h99, 4'b1111, 32'd0);
        chk("flags after AND/NOP", 32'(flags), 32'(FZ | FC));
        chk_cond(4'd8, 1'b0);   // HI
        chk_cond(4'd9, 1'b1);   // LS
        chk_cond(4'd10, 1'b1);  // GE
        chk_cond(4'd12, 1'b0);  // GT
        chk_cond(4'd14, 1'b1);  // AL
        chk_cond(4'd15, 1'b0);  // NV

        // GE/LT with N!=V, and mem_ack outside MEM ignored
        issue(UOP_CMP, 4'd0, 1'b0, 32'd0, FN, 32'd0);
        chk_cond(4'd11, 1'b1);
        chk_cond(4'd13, 1'b1);
        mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
        tick();
        mem_ack = 1'b0;
        chk("stray ack mem_req", 32'(mem_req), 32'd0);

        // LDR, ack on the third MEM cycle
        mem_q.push_back('{1'b0, 32'h100, 32'd0});
        issue(UOP_LDR, 4'd7, 1'b0, 32'h100, 4'b0000, 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("ldr mem_req", 32'(mem_req), 32'd1);
            chk("ldr in_ready", 32'(in_ready), 32'd0);
            if (i == 2) begin
                mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
                rf_q.push_back('{4'd7, 32'hDEAD_BEEF});
            end
            tick();
        end
        mem_ack = 1'b0;
        chk("ldwb mem_req", 32'(mem_req), 32'd0);
        chk("ldwb in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("ldr done in_ready", 32'(in_ready), 32'd1);
        chk("flags after LDR", 32'(flags), 32'(FN));

        // LDR acked on the timeout cycle: ack wins
        mem_q.push_back('{1'b0, 32'h300, 32'd0});
        issue(UOP_LDR, 4'd9, 1'b0, 32'h300, 4'b0000, 32'd0);
        repeat (254) tick();
        chk("ldr edge mem_req", 32'(mem_req), 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        rf_q.push_back('{4'd9, 32'h1234_5678});
        tick();
        mem_ack = 1'b0;
        chk("edge ack fault", 32'(fault), 32'd0);
        chk("edge ack mem_req", 32'(mem_req), 32'd0);
        tick();

        // STR with no ack: times out after 255 cycles
        mem_q.push_back('{1'b1, 32'h20, 32'hAB});
        issue(UOP_STR, 4'd0, 1'b0, 32'h20, 4'b0000, 32'hAB);
        n = 0;
        while (mem_req === 1'b1 && n < 300) begin
            n++;
            tick();
        end
        chk("timeout req cycles", 32'(n), 32'd255);
        chk("timeout fault", 32'(fault), 32'd1);
        chk("timeout in_ready", 32'(in_ready), 32'd1);
        rf_q.push_back('{4'd8, 32'h77});
        issue(UOP_ADD, 4'd8, 1'b1, 32'h77, FV, 32'd0);
        chk("fault sticky", 32'(fault), 32'd1);

        // Reset while a STR waits in MEM
        mem_q.push_back('{1'b1, 32'h40, 32'hCD});
        issue(UOP_STR, 4'd0, 1'b0, 32'h40, 4'b0000, 32'hCD);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("rst mem_req", 32'(mem_req), 32'd0);
        chk("rst flags", 32'(flags), 32'd0);
        chk("rst fault", 32'(fault), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd1);
        rf_q.push_back('{4'd3, 32'h0000_00A5});
        issue(UOP_ADD, 4'd3, 1'b0, 32'hA5, 4'b0000, 32'd0);
        tick(); tick();

        chk("rf queue drained", 32'(rf_q.size()), 32'd0);
        chk("mem queue drained", 32'(mem_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Sits directly downstream of the ALU. Consumes its 32-bit result and [Z,C,N,V] flags together with the decoded micro-op.
- Owns the architectural flags register and drives the condition-pass signal used by branch/conditional logic.
- Performs the STR/LDR memory transaction using the ALU-computed address.
- Issues the single register-file write for each retired micro-op.

Parameters:
DATA_W, 32, datapath width
REG_AW, 4, register-file address width (16 registers)
MEM_TIMEOUT, 255, max cycles waiting for mem_ack before abort

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
in_valid  in  1  upstream has a micro-op to retire
in_ready  out  1  stage can accept a micro-op this cycle
uop  in  5  micro-op code (shared package encoding)
rd  in  REG_AW  destination register
set_flags  in  1  update flags register (ignored for CMP, which always updates)
alu_out  in  DATA_W  ALU result (address for STR/LDR)
alu_flags  in  4  ALU flags, bit order [0:3] = [Z,C,N,V]
store_data  in  DATA_W  data to store for STR
cond  in  4  condition code to evaluate
cond_pass  out  1  cond satisfied by current flags register
flags  out  4  architectural flags [Z,C,N,V]
mem_req  out  1  memory request
mem_we  out  1  1 = write (STR), 0 = read (LDR)
mem_addr  out  DATA_W  memory address
mem_wdata  out  DATA_W  store data
mem_ack  in  1  memory completes request this cycle
mem_rdata  in  DATA_W  load data, valid with mem_ack
rf_we  out  1  register-file write enable (one-cycle pulse)
rf_waddr  out  REG_AW  write address
rf_wdata  out  DATA_W  write data
fault  out  1  sticky memory-timeout indicator

Behaviour:
- Reset: state IDLE. All registered outputs are 0: flags=0000, rf_*, mem_*, fault, timeout counter. in_ready=0 while reset is high.
- in_ready = (state==IDLE). A micro-op is accepted when in_valid && in_ready.
- FSM states: IDLE, MEM, LDWB.
- IDLE, accept ADD/SUB/AND/EOR/LSL/LSR/MOV:
  - Next cycle: rf_we=1, rf_waddr=rd, rf_wdata=alu_out (latency 1).
  - Stay IDLE, so back-to-back accepts are allowed.
- IDLE, accept CMP: no register write; flags updated.
- IDLE, accept STR: go to MEM. Next cycle mem_req=1, mem_we=1, mem_addr=alu_out, mem_wdata=store_data.
- IDLE, accept LDR: go to MEM. Next cycle mem_req=1, mem_we=0, mem_addr=alu_out.
- IDLE, accept any other uop: treated as NOP; accepted with no effect.
- MEM:
  - mem_req and address/data held stable until mem_ack; the counter increments each MEM cycle.
  - On mem_ack:
    - mem_req drops next cycle.
    - STR returns to IDLE.
    - LDR latches mem_rdata and goes to LDWB.
  - If the counter reaches MEM_TIMEOUT without ack: mem_req drops, fault=1 (sticky until reset), return to IDLE, no register write.
  - An ack arriving in the same cycle as the timeout wins.
- LDWB: one cycle of rf_we=1, rf_waddr=rd, rf_wdata=loaded data, then IDLE.
- mem_ack outside MEM is ignored.
- Flags update (registered, visible the cycle after accept):
  - ADD/SUB/LSL with set_flags, and CMP always: flags ← alu_flags.
  - AND/EOR/LSR/MOV with set_flags: Z,N ← alu_flags; C,V unchanged.
  - STR/LDR/NOP: never update flags.
- cond_pass is combinational from the flags register:
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 MI: N
  - 5 PL: !N
  - 6 VS: V
  - 7 VC: !V
  - 8 HI: C&!Z
  - 9 LS: !C|Z
  - 10 GE: N==V
  - 11 LT: N!=V
  - 12 GT: !Z&(N==V)
  - 13 LE: Z|(N!=V)
  - 14 AL: 1
  - 15: 0
- Reset mid-transaction: the FSM aborts to IDLE, mem_req is 0 the following cycle, and no register write occurs.

Decomposition:
- The shared Utilities package holds:
  - the uop encoding (ADD..LDR);
  - flag index constants FLAG_Z=0, FLAG_C=1, FLAG_N=2, FLAG_V=3;
  - the condition-code enum (EQ..AL, NV);
  - the FSM state enum.
- One sub-module: cond_check, the purely combinational flags+cond → pass evaluator, reusable by the fetch/branch unit.

Test Plan:
- ADD, rd=3, alu_out=0x0000_0005, set_flags=1, alu_flags=0100 -> next cycle rf_we=1, rf_waddr=3, rf_wdata=5; flags=0100; cond=2 (CS) gives cond_pass=1.
- CMP, alu_out=0, alu_flags=1000, set_flags=0 -> no rf_we; flags=1000; cond=0 gives pass=1; cond=1 gives pass=0.
- Flags=0110 then MOV, set_flags=1, alu_flags=1000 -> flags=1100 (C kept, V kept at 0, N cleared).
- LDR, alu_out=0x100, rd=7, mem_ack after 3 cycles with rdata=0xDEADBEEF:
  - mem_req=1, mem_we=0, addr=0x100 held for 3 cycles;
  - in_ready=0 throughout;
  - then a single rf_we with rf_waddr=7, rf_wdata=0xDEADBEEF.
- STR, alu_out=0x20, store_data=0xAB, mem_ack never asserted -> after 255 cycles mem_req drops, fault=1, in_ready=1, no rf_we; fault stays 1 until reset.
- STR waiting in MEM, reset pulsed for 1 cycle -> mem_req=0, flags=0000, fault=0; a new ADD is accepted in the cycle reset deasserts.
